// File: rtl/tres_b_pkg.sv
// Shared types and constants for the tres_b four-input Boolean function block.
// Default truth table marks the prime indices 2, 3, 5, 7, 11 and 13.
package tres_b_pkg;

  localparam logic [15:0] TRESB_PRIME_TABLE = 16'h28AC;

  typedef logic [3:0] tresb_idx_t;

endpackage

// File: rtl/tres_b_lut.sv
// Purely combinational 16-entry lookup: f = TRUTH_TABLE[idx].
module tres_b_lut
  import tres_b_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TRESB_PRIME_TABLE
) (
  input  tresb_idx_t idx,
  output logic       f
);

  assign f = TRUTH_TABLE[idx];

endmodule

// File: rtl/tres_b.sv
// Four-input Boolean function: x is the registered TRUTH_TABLE[{a,b,c,d}] lookup.
// Async active-high reset clears x; otherwise x reloads on every rising clock edge.
module tres_b
  import tres_b_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = TRESB_PRIME_TABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic x
);

  tresb_idx_t idx_p0;
  logic       f_p0;
  logic       x_p1;

  assign idx_p0 = {a, b, c, d};

  tres_b_lut #(
    .TRUTH_TABLE(TRUTH_TABLE)
  ) u_lut (
    .idx(idx_p0),
    .f  (f_p0)
  );

  // p0 -> p1: output register, cleared asynchronously so x is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p1 <= 1'b0;
    end else begin
      x_p1 <= f_p0;
    end
  end

  assign x = x_p1;

endmodule

// File: tb/tb_tres_b.sv
// Self-checking bench for tres_b: default prime table plus a 16'h8001 override instance.
module tb_tres_b;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic x_def;
  logic x_ovr;

  int tests;
  int fails;

  tres_b u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .x(x_def)
  );

  tres_b #(
    .TRUTH_TABLE(16'h8001)
  ) u_ovr (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .x(x_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: primality by trial division, independent of any table.
  function automatic logic ref_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) begin
      if (n % k == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic ref_ovr(input int n);
    return (n == 0 || n == 15);
  endfunction

  task automatic drive(input int n);
    logic [3:0] v;
    v = n[3:0];
    {a, b, c, d} = v;
  endtask

  task automatic test_reset;
    drive(7);
    @(posedge clk); #1;
    tests++;
    if (x_def !== 1'b1) begin
      fails++; $display("FAIL pre_reset_load x=%b expected=1", x_def);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (x_def !== 1'b0 || x_ovr !== 1'b0) begin
      fails++; $display("FAIL async_reset x=%b x_ovr=%b expected=0,0", x_def, x_ovr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) drive((i == 0) ? 15 : 7);
      @(posedge clk); #1;
      tests++;
      if (x_def !== 1'b0 || x_ovr !== 1'b0) begin
        fails++; $display("FAIL reset_hold cyc=%0d x=%b x_ovr=%b expected=0,0", i, x_def, x_ovr);
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_sweep;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk) drive(n);
      @(posedge clk); #1;
      tests++;
      if (x_def !== ref_prime(n) || x_ovr !== ref_ovr(n)) begin
        fails++;
        $display("FAIL sweep N=%0d x=%b x_ovr=%b expected=%b,%b", n, x_def, x_ovr, ref_prime(n), ref_ovr(n));
      end
      if (n == 7) begin
        #2 rst = 1'b1;
        #1;
        tests++;
        if (x_def !== 1'b0) begin
          fails++; $display("FAIL midstream_reset x=%b expected=0", x_def);
        end
        #5 rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (x_def !== ref_prime(7)) begin
          fails++; $display("FAIL midstream_resume x=%b expected=%b", x_def, ref_prime(7));
        end
      end
    end
  endtask

  task automatic test_spot;
    int   idx [4] = '{4'b0010, 4'b1001, 4'b1101, 4'b1111};
    logic exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) drive(idx[i]);
      @(posedge clk); #1;
      tests++;
      if (x_def !== exp[i]) begin
        fails++; $display("FAIL spot abcd=%4b x=%b expected=%b", idx[i][3:0], x_def, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int q [$];
    int n;
    for (int i = 0; i < 48; i++) begin
      n = int'($urandom_range(0, 15));
      q.push_back(n);
      @(negedge clk) drive(n);
      @(posedge clk); #1;
      n = q.pop_front();
      tests++;
      if (x_def !== ref_prime(n) || x_ovr !== ref_ovr(n)) begin
        fails++;
        $display("FAIL back_to_back i=%0d N=%0d x=%b x_ovr=%b expected=%b,%b", i, n, x_def, x_ovr, ref_prime(n), ref_ovr(n));
      end
    end
  endtask

  task automatic test_hold;
    @(negedge clk) drive(11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (x_def !== 1'b1) begin
        fails++; $display("FAIL hold_rise cyc=%0d x=%b expected=1", i, x_def);
      end
      @(negedge clk); #1;
      tests++;
      if (x_def !== 1'b1) begin
        fails++; $display("FAIL hold_fall cyc=%0d x=%b expected=1", i, x_def);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    drive(7);
    test_reset();
    test_sweep();
    test_spot();
    test_back_to_back();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
